// File: rtl/vga_pkg.sv
// vga_pkg: shared pixel, control tuple and lock state types for the VGA output path
package vga_pkg;
  typedef logic [23:0] pixel_t;
  typedef struct packed {
    logic   hs;
    logic   vs;
    logic   de;
    logic   img;
    logic   hl;
    pixel_t overlay;
  } ctrl_t;
  typedef enum logic {WAIT_FRAME, LOCKED} lock_state_t;
  localparam pixel_t BG_COLOR_DEF  = 24'h202020;
  localparam pixel_t KEY_COLOR_DEF = 24'hFF00FF;
  localparam ctrl_t  CTRL_IDLE     = '{hs: 1'b1, vs: 1'b1, de: 1'b0, img: 1'b0, hl: 1'b0, overlay: 24'h0};
endpackage

// File: rtl/ctrl_delay_line.sv
// ctrl_delay_line: fixed-depth shift register for the control tuple with a settable reset value
module ctrl_delay_line
  import vga_pkg::*;
#(
  parameter int    DEPTH   = 2,
  parameter ctrl_t RST_VAL = CTRL_IDLE
) (
  input  logic  clk,
  input  logic  rst,
  input  ctrl_t d,
  output ctrl_t q
);
  ctrl_t sr [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/vga_pixel_compositor.sv
// vga_pixel_compositor: aligns control with ROM read latency and composites image/overlay/background onto the DAC
module vga_pixel_compositor
  import vga_pkg::*;
#(
  parameter int     R_WIDTH            = 8,
  parameter int     G_WIDTH            = 8,
  parameter int     B_WIDTH            = 8,
  parameter int     ROM_ADDR_BUS_WIDTH = 17,
  parameter int     ROM_LATENCY        = 2,
  parameter pixel_t BG_COLOR           = BG_COLOR_DEF,
  parameter pixel_t KEY_COLOR          = KEY_COLOR_DEF
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic                          display_on,
  input  logic [ROM_ADDR_BUS_WIDTH-1:0] ROM_Addr,
  input  logic                          isImage,
  input  logic [23:0]                   PixelBus,
  input  logic                          inHighlightedArea,
  output logic [ROM_ADDR_BUS_WIDTH-1:0] ROM_Addr_Out,
  input  logic [23:0]                   ROM_Data,
  output logic [R_WIDTH-1:0]            VGA_R,
  output logic [G_WIDTH-1:0]            VGA_G,
  output logic [B_WIDTH-1:0]            VGA_B,
  output logic                          VGA_HS,
  output logic                          VGA_VS,
  output logic                          VGA_BLANK_N,
  output logic                          frame_locked
);
  ctrl_t       in_t, d_t;
  lock_state_t state;
  logic        vs_q, fall, gate;
  pixel_t      col;
  assign in_t = '{hs: hsync_in, vs: vsync_in, de: display_on, img: isImage,
                  hl: inHighlightedArea, overlay: PixelBus};
  // Stage 0 plus ROM_LATENCY-1 stages; the output register is the last stage
  ctrl_delay_line #(.DEPTH(ROM_LATENCY), .RST_VAL(CTRL_IDLE)) u_delay (
    .clk(CLK),
    .rst(RST),
    .d  (in_t),
    .q  (d_t)
  );
  assign fall = vs_q & ~VGA_VS;
  // The cycle that detects the edge already lets colour through
  assign gate = (state == LOCKED) || fall;
  assign frame_locked = (state == LOCKED);
  always_comb col = (!d_t.de || !gate) ? '0 :
                    d_t.hl             ? d_t.overlay :
                    d_t.img            ? ((ROM_Data != KEY_COLOR) ? ROM_Data : BG_COLOR) :
                                         d_t.overlay;
  always_ff @(posedge CLK) begin
    if (RST) begin
      ROM_Addr_Out <= '0;
      VGA_R        <= '0;
      VGA_G        <= '0;
      VGA_B        <= '0;
      VGA_HS       <= 1'b1;
      VGA_VS       <= 1'b1;
      VGA_BLANK_N  <= 1'b0;
      vs_q         <= 1'b1;
      state        <= WAIT_FRAME;
    end else begin
      ROM_Addr_Out <= ROM_Addr;
      VGA_R        <= col[23 -: R_WIDTH];
      VGA_G        <= col[15 -: G_WIDTH];
      VGA_B        <= col[7 -: B_WIDTH];
      VGA_HS       <= d_t.hs;
      VGA_VS       <= d_t.vs;
      VGA_BLANK_N  <= d_t.de & gate;
      vs_q         <= VGA_VS;
      if (fall) state <= LOCKED;
    end
  end
endmodule

// File: tb/tb_vga_pixel_compositor.sv
// tb_vga_pixel_compositor: directed checks of latency, compositing priority and frame lock
module tb_vga_pixel_compositor;
  logic        clk = 0;
  logic        rst = 1;
  logic        hs = 1, vs = 1, de = 0, img = 0, hl = 0;
  logic [16:0] addr = '0;
  logic [23:0] pb = '0;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  function automatic logic [23:0] rom_f(logic [16:0] a);
    return a == 17'h00123 ? 24'h11AA55 : a == 17'h00124 ? 24'hFF00FF : {7'h0, a};
  endfunction

  logic [16:0] ao1, ao2, ao4;
  logic [23:0] rd1, rd2, rd4, r4a, r4b;
  logic [7:0]  r1, g1, b1, r2, g2, b2, r4, g4, b4;
  logic        hs1, vs1, bl1, lk1, hs2, vs2, bl2, lk2, hs4, vs4, bl4, lk4;

  // ROM models: total latency from ROM_Addr counts the ROM_Addr_Out register as one cycle
  assign rd1 = rom_f(ao1);
  always @(posedge clk) rd2 <= rom_f(ao2);
  always @(posedge clk) begin
    r4a <= rom_f(ao4);
    r4b <= r4a;
    rd4 <= r4b;
  end

  vga_pixel_compositor #(.ROM_LATENCY(1)) dut1 (
    .CLK(clk), .RST(rst), .hsync_in(hs), .vsync_in(vs), .display_on(de), .ROM_Addr(addr),
    .isImage(img), .PixelBus(pb), .inHighlightedArea(hl), .ROM_Addr_Out(ao1), .ROM_Data(rd1),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1), .VGA_BLANK_N(bl1),
    .frame_locked(lk1));
  vga_pixel_compositor #(.ROM_LATENCY(2)) dut2 (
    .CLK(clk), .RST(rst), .hsync_in(hs), .vsync_in(vs), .display_on(de), .ROM_Addr(addr),
    .isImage(img), .PixelBus(pb), .inHighlightedArea(hl), .ROM_Addr_Out(ao2), .ROM_Data(rd2),
    .VGA_R(r2), .VGA_G(g2), .VGA_B(b2), .VGA_HS(hs2), .VGA_VS(vs2), .VGA_BLANK_N(bl2),
    .frame_locked(lk2));
  vga_pixel_compositor #(.ROM_LATENCY(4)) dut4 (
    .CLK(clk), .RST(rst), .hsync_in(hs), .vsync_in(vs), .display_on(de), .ROM_Addr(addr),
    .isImage(img), .PixelBus(pb), .inHighlightedArea(hl), .ROM_Addr_Out(ao4), .ROM_Data(rd4),
    .VGA_R(r4), .VGA_G(g4), .VGA_B(b4), .VGA_HS(hs4), .VGA_VS(vs4), .VGA_BLANK_N(bl4),
    .frame_locked(lk4));

  // {colour, HS, VS, BLANK_N, frame_locked}
  wire [27:0] o1 = {r1, g1, b1, hs1, vs1, bl1, lk1};
  wire [27:0] o2 = {r2, g2, b2, hs2, vs2, bl2, lk2};
  wire [27:0] o4 = {r4, g4, b4, hs4, vs4, bl4, lk4};

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    step(2);
    tests++;
    if (o2 !== {24'h0, 4'b1100}) begin
      fails++;
      $display("FAIL reset_outputs: got %h want %h", o2, {24'h0, 4'b1100});
    end
    tests++;
    if (ao2 !== 17'h0) begin
      fails++;
      $display("FAIL reset_rom_addr: got %h want 0", ao2);
    end
    rst = 0; de = 1; pb = 24'h123456; addr = 17'h00055;
    step(4);
    tests++;
    if (o2 !== {24'h0, 4'b1100}) begin
      fails++;
      $display("FAIL unlocked_black: got %h want %h", o2, {24'h0, 4'b1100});
    end
    tests++;
    if (ao2 !== 17'h00055) begin
      fails++;
      $display("FAIL rom_addr_follow: got %h want 00055", ao2);
    end
  endtask

  task automatic test_lock;
    pb = 24'hABCDEF;
    vs = 0;
    step(1);
    vs = 1;
    step(2);
    tests++;
    if (o2 !== {24'h0, 4'b1000}) begin
      fails++;
      $display("FAIL lock_edge_cycle: got %h want %h", o2, {24'h0, 4'b1000});
    end
    step(1);
    tests++;
    if (o2 !== {24'hABCDEF, 4'b1111}) begin
      fails++;
      $display("FAIL first_locked_pixel: got %h want %h", o2, {24'hABCDEF, 4'b1111});
    end
    step(3);
    tests++;
    if ({lk1, lk4} !== 2'b11) begin
      fails++;
      $display("FAIL lock_l1_l4: got %b want 11", {lk1, lk4});
    end
  endtask

  task automatic test_image;
    addr = 17'h00123; img = 1;
    step(1);
    tests++;
    if (ao2 !== 17'h00123) begin
      fails++;
      $display("FAIL rom_addr_out: got %h want 00123", ao2);
    end
    img = 0; pb = 24'h000001; addr = '0;
    step(1);
    tests++;
    if (o2 !== {24'hABCDEF, 4'b1111}) begin
      fails++;
      $display("FAIL image_early: got %h want %h", o2, {24'hABCDEF, 4'b1111});
    end
    step(1);
    tests++;
    if (o2 !== {24'h11AA55, 4'b1111}) begin
      fails++;
      $display("FAIL image_pixel: got %h want %h", o2, {24'h11AA55, 4'b1111});
    end
    step(1);
    tests++;
    if (o2 !== {24'h000001, 4'b1111}) begin
      fails++;
      $display("FAIL image_next: got %h want %h", o2, {24'h000001, 4'b1111});
    end
  endtask

  task automatic test_key;
    addr = 17'h00124; img = 1;
    step(3);
    tests++;
    if (o2 !== {24'h202020, 4'b1111}) begin
      fails++;
      $display("FAIL key_to_bg: got %h want %h", o2, {24'h202020, 4'b1111});
    end
  endtask

  task automatic test_highlight;
    hl = 1; img = 1; addr = 17'h00123; pb = 24'h0000FF;
    step(3);
    tests++;
    if (o2 !== {24'h0000FF, 4'b1111}) begin
      fails++;
      $display("FAIL highlight_wins: got %h want %h", o2, {24'h0000FF, 4'b1111});
    end
    hl = 0; img = 0; pb = 24'h445566;
    step(3);
    tests++;
    if (o2 !== {24'h445566, 4'b1111}) begin
      fails++;
      $display("FAIL overlay: got %h want %h", o2, {24'h445566, 4'b1111});
    end
    de = 0;
    step(3);
    tests++;
    if (o2 !== {24'h0, 4'b1101}) begin
      fails++;
      $display("FAIL display_off: got %h want %h", o2, {24'h0, 4'b1101});
    end
  endtask

  task automatic test_latency_sweep;
    de = 0; img = 0; hl = 0; pb = '0; addr = '0;
    step(6);
    hs = 0; de = 1; img = 1; addr = 17'h00123;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      if (i == 1) begin
        hs = 1; de = 0; img = 0; addr = '0;
      end
      tests++;
      if (o1 !== ((i == 2) ? {24'h11AA55, 4'b0111} : {24'h0, 4'b1101})) begin
        fails++;
        $display("FAIL sweep_l1 step %0d: got %h want %h", i, o1,
                 (i == 2) ? {24'h11AA55, 4'b0111} : {24'h0, 4'b1101});
      end
      tests++;
      if (o4 !== ((i == 5) ? {24'h11AA55, 4'b0111} : {24'h0, 4'b1101})) begin
        fails++;
        $display("FAIL sweep_l4 step %0d: got %h want %h", i, o4,
                 (i == 5) ? {24'h11AA55, 4'b0111} : {24'h0, 4'b1101});
      end
    end
  endtask

  task automatic test_reset_mid;
    de = 1; pb = 24'hABCDEF; addr = 17'h00077;
    step(4);
    rst = 1;
    step(1);
    tests++;
    if (o2 !== {24'h0, 4'b1100}) begin
      fails++;
      $display("FAIL mid_reset: got %h want %h", o2, {24'h0, 4'b1100});
    end
    tests++;
    if (ao2 !== 17'h0) begin
      fails++;
      $display("FAIL mid_reset_addr: got %h want 0", ao2);
    end
    rst = 0;
    step(5);
    tests++;
    if (o2 !== {24'h0, 4'b1100}) begin
      fails++;
      $display("FAIL post_reset_black: got %h want %h", o2, {24'h0, 4'b1100});
    end
    vs = 0;
    step(1);
    vs = 1;
    step(2);
    tests++;
    if (o2 !== {24'h0, 4'b1000}) begin
      fails++;
      $display("FAIL relock_edge: got %h want %h", o2, {24'h0, 4'b1000});
    end
    step(1);
    tests++;
    if (o2 !== {24'hABCDEF, 4'b1111}) begin
      fails++;
      $display("FAIL relock_pixel: got %h want %h", o2, {24'hABCDEF, 4'b1111});
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset;
    test_lock;
    test_image;
    test_key;
    test_highlight;
    test_latency_sweep;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
